// File: rtl/led_decoder_seq_if.sv
// led_decoder_seq_if: switch-side inputs and LED output of the LED decoder.
//   enable [2:0]     : 74x138-style enable code, active when 3'b100
//   switch [SEL_W-1:0]: LED select index
//   mode   [1:0]     : 00 DECODE, 01 SCAN, 10 BLINK, 11 reserved (idle)
//   led    [OUT_W-1:0]: active-low LED bank, driven by the decoder
// Modports: master drives the inputs and observes led; slave is the decoder.
interface led_decoder_seq_if #(
    parameter int unsigned SEL_W = 3
);
    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic [2:0]       enable;
    logic [SEL_W-1:0] switch;
    logic [1:0]       mode;
    logic [OUT_W-1:0] led;

    modport master (output enable, output switch, output mode, input led);
    modport slave  (input enable, input switch, input mode, output led);
endinterface

// File: rtl/led_decoder_seq.sv
// led_decoder_seq: registered SEL_W-to-2**SEL_W one-hot decoder for active-low
// LEDs with plain decode, walking-LED scan and blinking modes, paced by an
// internal PRESCALE_W-bit prescaler (one tick every 2**PRESCALE_W cycles).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active low
//   bus  : led_decoder_seq_if.slave (enable, switch, mode in; led out)
// Optional feature: define LED_DECODER_BOUNCE_EN to make SCAN ping-pong
// between 0 and OUT_W-1 instead of wrapping upward.
module led_decoder_seq #(
    parameter int unsigned SEL_W      = 3,
    parameter int unsigned PRESCALE_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    led_decoder_seq_if.slave     bus
);
    localparam int unsigned OUT_W = 2 ** SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_SCAN   = 2'd2,
        ST_BLINK  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [SEL_W-1:0]      pos_q, pos_d;
    logic                  phase_q, phase_d;
    logic [OUT_W-1:0]      led_q, led_d;
`ifdef LED_DECODER_BOUNCE_EN
    logic                  dir_up_q, dir_up_d;
`endif

    logic tick;

    // Active-low one-hot pattern, shift done at full LED width.
    function automatic logic [OUT_W-1:0] dec_n(input logic [SEL_W-1:0] idx);
        logic [OUT_W-1:0] one;
        one = OUT_W'(1);
        return ~(one << idx);
    endfunction

    assign tick    = (psc_q == '1);
    assign bus.led = led_q;

    // Next state, prescaler, scan position, blink phase and LED pattern.
    always_comb begin
        state_d  = ST_IDLE;
        psc_d    = psc_q;
        pos_d    = pos_q;
        phase_d  = phase_q;
        led_d    = '1;
`ifdef LED_DECODER_BOUNCE_EN
        dir_up_d = dir_up_q;
`endif

        if (bus.enable == 3'b100) begin
            case (bus.mode)
                2'b00:   state_d = ST_DECODE;
                2'b01:   state_d = ST_SCAN;
                2'b10:   state_d = ST_BLINK;
                default: state_d = ST_IDLE;
            endcase
        end

        case (state_d)
            ST_DECODE: begin
                led_d = dec_n(bus.switch);
            end

            ST_SCAN: begin
                if (state_q != ST_SCAN) begin
                    // Entry: load start position, restart prescaler.
                    pos_d    = bus.switch;
                    psc_d    = '0;
`ifdef LED_DECODER_BOUNCE_EN
                    dir_up_d = 1'b1;
`endif
                end else begin
                    psc_d = psc_q + PRESCALE_W'(1);
                    if (tick) begin
`ifdef LED_DECODER_BOUNCE_EN
                        // Turn around at the ends so each endpoint is shown once.
                        if (dir_up_q) begin
                            if (pos_q == SEL_W'(OUT_W - 1)) begin
                                dir_up_d = 1'b0;
                                pos_d    = pos_q - SEL_W'(1);
                            end else begin
                                pos_d    = pos_q + SEL_W'(1);
                            end
                        end else begin
                            if (pos_q == '0) begin
                                dir_up_d = 1'b1;
                                pos_d    = pos_q + SEL_W'(1);
                            end else begin
                                pos_d    = pos_q - SEL_W'(1);
                            end
                        end
`else
                        pos_d = pos_q + SEL_W'(1);
`endif
                    end
                end
                led_d = dec_n(pos_d);
            end

            ST_BLINK: begin
                if (state_q != ST_BLINK) begin
                    phase_d = 1'b1;
                    psc_d   = '0;
                end else begin
                    psc_d = psc_q + PRESCALE_W'(1);
                    if (tick) begin
                        phase_d = ~phase_q;
                    end
                end
                led_d = phase_d ? dec_n(bus.switch) : '1;
            end

            default: begin
                led_d = '1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            psc_q    <= '0;
            pos_q    <= '0;
            phase_q  <= 1'b1;
            led_q    <= '1;
`ifdef LED_DECODER_BOUNCE_EN
            dir_up_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            psc_q    <= psc_d;
            pos_q    <= pos_d;
            phase_q  <= phase_d;
            led_q    <= led_d;
`ifdef LED_DECODER_BOUNCE_EN
            dir_up_q <= dir_up_d;
`endif
        end
    end
endmodule

// File: tb/tb_led_decoder_seq.sv
// tb_led_decoder_seq: self-checking bench for led_decoder_seq with
// SEL_W=3, PRESCALE_W=2. A mode/entry-time model predicts led every cycle;
// directed literal checks pin the model on the documented scenarios, then
// randomized stimulus exercises mode changes, disables and resets.
module tb_led_decoder_seq;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned PSC_W  = 2;
    localparam int unsigned OUT_W  = 8;
    localparam int          PERIOD = 4;   // 2**PSC_W cycles per tick

    logic clk;
    logic rst;
    led_decoder_seq_if #(.SEL_W(SEL_W)) bus ();

    led_decoder_seq #(.SEL_W(SEL_W), .PRESCALE_W(PSC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_mode: 0 DECODE, 1 SCAN, 2 BLINK, 3 IDLE. An entry is any edge where
    // the active mode differs from the previous one; timed modes are then a
    // pure function of edges elapsed since entry.
    int          m_mode  = 3;
    int          m_edge  = 0;
    int          m_entry = 0;
    int          m_start = 0;
    logic [7:0]  m_exp   = 8'hFF;

    function automatic logic [7:0] onehot_n(input int idx);
        logic [7:0] one;
        one = 8'd1;
        return ~(one << idx);
    endfunction

    function automatic int scan_pos(input int s, input int n);
`ifdef LED_DECODER_BOUNCE_EN
        int u;
        u = (s + n) % (2 * (OUT_W - 1));
        return (u <= OUT_W - 1) ? u : 2 * (OUT_W - 1) - u;
`else
        return (s + n) % OUT_W;
`endif
    endfunction

    always @(posedge clk) begin
        int want;
        int n;
        m_edge++;
        if (!rst) begin
            m_mode = 3;
            m_exp  = 8'hFF;
        end else begin
            want = (bus.enable == 3'b100) ? int'(bus.mode) : 3;
            if (want != m_mode) begin
                m_entry = m_edge;
                m_start = int'(bus.switch);
            end
            m_mode = want;
            n = (m_edge - m_entry) / PERIOD;
            case (m_mode)
                0:       m_exp = onehot_n(int'(bus.switch));
                1:       m_exp = onehot_n(scan_pos(m_start, n));
                2:       m_exp = (n % 2 == 0) ? onehot_n(int'(bus.switch)) : 8'hFF;
                default: m_exp = 8'hFF;
            endcase
        end
    end

    // Every-cycle comparison, away from the clock edge.
    always @(posedge clk) begin
        #2;
        check("cycle", bus.led, m_exp);
    end

    // ---------------- stimulus ----------------
    task automatic set_in(input logic [2:0] en, input logic [1:0] md, input logic [2:0] sw);
        bus.enable = en;
        bus.mode   = md;
        bus.switch = sw;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    initial begin
        logic [7:0] scan_k8;
        int hold;
`ifdef LED_DECODER_BOUNCE_EN
        scan_k8 = 8'hBF;
`else
        scan_k8 = 8'hFE;
`endif
        rst = 1'b0;
        set_in(3'b000, 2'b00, 3'd0);
        repeat (2) @(negedge clk);
        check("reset_idle", bus.led, 8'hFF);
        rst = 1'b1;

        // Plain decode.
        @(negedge clk) set_in(3'b100, 2'b00, 3'd5);
        wait_edges(1); check("dec_sw5", bus.led, 8'hDF);
        @(negedge clk) bus.switch = 3'd0;
        wait_edges(1); check("dec_sw0", bus.led, 8'hFE);

        // Disable codes and reserved mode.
        @(negedge clk) bus.enable = 3'b101;
        wait_edges(1); check("en_101", bus.led, 8'hFF);
        @(negedge clk) bus.enable = 3'b000;
        wait_edges(1); check("en_000", bus.led, 8'hFF);
        @(negedge clk) bus.enable = 3'b110;
        wait_edges(1); check("en_110", bus.led, 8'hFF);
        @(negedge clk) set_in(3'b100, 2'b11, 3'd0);
        wait_edges(1); check("mode_11", bus.led, 8'hFF);

        // Scan from 6: wraps (or bounces) after 7.
        @(negedge clk) set_in(3'b100, 2'b01, 3'd6);
        wait_edges(1); check("scan_entry", bus.led, 8'hBF);
        wait_edges(3); check("scan_hold", bus.led, 8'hBF);
        wait_edges(1); check("scan_step1", bus.led, 8'h7F);
        wait_edges(4); check("scan_step2", bus.led, scan_k8);

        // Blink on switch 2, then live switch change in the on phase.
        @(negedge clk) set_in(3'b100, 2'b10, 3'd2);
        wait_edges(1); check("blink_entry", bus.led, 8'hFB);
        wait_edges(3); check("blink_on_end", bus.led, 8'hFB);
        wait_edges(1); check("blink_off", bus.led, 8'hFF);
        wait_edges(3); check("blink_off_end", bus.led, 8'hFF);
        wait_edges(1); check("blink_on2", bus.led, 8'hFB);
        @(negedge clk) bus.switch = 3'd7;
        wait_edges(1); check("blink_live_sw", bus.led, 8'h7F);

        // Scan at 4, disable for three cycles, re-enter from a new switch.
        @(negedge clk) set_in(3'b100, 2'b01, 3'd4);
        wait_edges(1); check("scan4_entry", bus.led, 8'hEF);
        wait_edges(1);
        @(negedge clk) bus.enable = 3'b000;
        wait_edges(1); check("scan4_dis1", bus.led, 8'hFF);
        wait_edges(2); check("scan4_dis3", bus.led, 8'hFF);
        @(negedge clk) begin bus.enable = 3'b100; bus.switch = 3'd1; end
        wait_edges(1); check("reentry", bus.led, 8'hFD);
        wait_edges(3); check("reentry_hold", bus.led, 8'hFD);
        wait_edges(1); check("reentry_step", bus.led, 8'hFB);

        // Asynchronous reset mid-scan.
        @(negedge clk) set_in(3'b100, 2'b01, 3'd3);
        wait_edges(6);
        @(negedge clk);
        #1 rst = 1'b0;
        #1 check("rst_async", bus.led, 8'hFF);
        @(negedge clk) rst = 1'b1;
        wait_edges(1); check("rst_release", bus.led, 8'hF7);

        // Randomized traffic.
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
            if (hold == 0) begin
                bus.enable = ($urandom_range(0, 99) < 85) ? 3'b100 : 3'($urandom_range(0, 7));
                bus.mode   = 2'($urandom_range(0, 3));
                bus.switch = 3'($urandom_range(0, 7));
                hold       = $urandom_range(1, 30);
            end else begin
                hold--;
                if ($urandom_range(0, 9) == 0)
                    bus.switch = 3'($urandom_range(0, 7));
            end
        end

        wait_edges(1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
